operand_entry: RTL and testbench

Keypad operand-entry controller for the calculator datapath. It converts a stream of 4-bit key codes, qualified by a raw `pressed` level, into two registered decimal operands `x` and `y` and a 2-bit operator code `op`. The number of decimal digits per operand and the operand width are parameters. It sits between the keypad/switch front end and the arithmetic unit and display drivers.

---
 rtl/operand_entry.sv | 164 ++++++++++++++++
 tb/tb_operand_entry.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_entry.sv
// Keypad operand entry: turns synchronized key events into registered operands x/y and operator op.
// Latency: a key event is consumed on the 3rd rising edge that samples pressed=1; outputs update on that edge.
// Backpressure: none; one event per pressed low->high transition, and pressed must stay low >=2 edges between keys.
// Optional feature: OPERAND_ENTRY_AUTOSWAP_EN moves the selection to Y after a full-length digit commit to X.
module operand_entry #(
    parameter int DIGITS = 2,
    parameter int W      = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   num,
    input  logic         pressed,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic [1:0]   op,
    output logic         ledX,
    output logic         ledY,
    output logic         commit
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [63:0] MAX_VAL = (64'd10 ** DIGITS) - 64'd1;
    localparam logic [63:0] MAX_REP = (64'd1 << W) - 64'd1;

    // Reject parameter sets where the largest DIGITS-digit number does not fit in W bits.
    generate
        if (DIGITS < 1 || MAX_VAL > MAX_REP) begin : g_bad_params
            $error("operand_entry: illegal DIGITS/W combination");
        end
    endgenerate

    typedef enum logic {S_IDLE = 1'b0, S_ENTRY = 1'b1} state_t;

    state_t         state_q, state_d;
    logic           sync1_q, sync2_q, prev_q;
    logic           sel_q, sel_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   x_q, x_d;
    logic [W-1:0]   y_q, y_d;
    logic [1:0]     op_q, op_d;
    logic           commit_q, commit_d;

    logic           key_evt;
    logic           in_entry;
    logic           last_digit;
    logic [W+3:0]   mac;
    logic           wr_en;
    logic [W-1:0]   wr_val;

    assign key_evt    = sync2_q & ~prev_q;
    assign in_entry   = (state_q == S_ENTRY);
    assign last_digit = (cnt_q == CW'(DIGITS - 1));
    assign mac        = ({4'b0000, acc_q} * (W+4)'(10)) + {{W{1'b0}}, num};

    // Two-flop synchronizer for the raw press level plus the edge-detect history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= pressed;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // FSM state register together with the datapath registers it controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sel_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            op_q     <= 2'd0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            op_q     <= op_d;
            commit_q <= commit_d;
        end
    end

    // Next-state logic: decode the consumed key and decide accumulate / commit / select.
    always_comb begin
        sel_d    = sel_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        op_d     = op_q;
        wr_en    = 1'b0;
        wr_val   = acc_q;
        if (key_evt) begin
            if (num <= 4'd9) begin
                if (last_digit) begin
                    wr_en  = 1'b1;
                    wr_val = mac[W-1:0];
                    acc_d  = '0;
                    cnt_d  = '0;
`ifdef OPERAND_ENTRY_AUTOSWAP_EN
                    // Only a completed X operand hands entry over to Y.
                    if (!sel_q) begin
                        sel_d = 1'b1;
                    end
`endif
                end else begin
                    acc_d = mac[W-1:0];
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (num <= 4'd13) begin
                // A partially typed operand is committed as-is when an operator arrives.
                wr_en = in_entry;
                acc_d = '0;
                cnt_d = '0;
                case (num)
                    4'd10:   op_d = 2'd1;
                    4'd11:   op_d = 2'd2;
                    4'd12:   op_d = 2'd3;
                    default: op_d = 2'd0;
                endcase
            end else begin
                // Partial entry lands in the operand selected before the switch.
                wr_en = in_entry;
                sel_d = num[0];
                acc_d = '0;
                cnt_d = '0;
            end
        end
        if (wr_en) begin
            if (sel_q) begin
                y_d = wr_val;
            end else begin
                x_d = wr_val;
            end
        end
        commit_d = wr_en;
    end

    // FSM next state: ENTRY whenever digits are pending in the accumulator.
    always_comb begin
        state_d = (cnt_d == '0) ? S_IDLE : S_ENTRY;
    end

    // Output decode: target LEDs follow the selection directly.
    always_comb begin
        ledX = ~sel_q;
        ledY = sel_q;
    end

    assign x      = x_q;
    assign y      = y_q;
    assign op     = op_q;
    assign commit = commit_q;

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry (DIGITS=2, W=7): directed scenarios plus random keys vs a behavioural model.
// Latency: each key is checked before and on its consuming edge, and one cycle later.
// Backpressure: n/a; presses are spaced with the required low gap.
module tb_operand_entry;

    localparam int DIGITS = 2;
    localparam int W      = 7;

    logic         clk;
    logic         rst_n;
    logic [3:0]   num;
    logic         pressed;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [1:0]   op;
    logic         ledX;
    logic         ledY;
    logic         commit;

    int checks;
    int failures;

    // Behavioural model of the operand entry state.
    int m_sel, m_acc, m_cnt, m_x, m_y, m_op, m_commit;

    operand_entry #(.DIGITS(DIGITS), .W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .num     (num),
        .pressed (pressed),
        .x       (x),
        .y       (y),
        .op      (op),
        .ledX    (ledX),
        .ledY    (ledY),
        .commit  (commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sel = 0; m_acc = 0; m_cnt = 0;
        m_x = 0; m_y = 0; m_op = 0; m_commit = 0;
    endtask

    task automatic model_write(input int val);
        if (m_sel == 1) m_y = val;
        else m_x = val;
        m_commit = 1;
    endtask

    // Apply one key to the model using the keypad's arithmetic rules.
    task automatic model_key(input int k);
        int was_x;
        m_commit = 0;
        if (k <= 9) begin
            if (m_cnt + 1 == DIGITS) begin
                was_x = (m_sel == 0);
                model_write((m_acc * 10 + k) % (1 << W));
                m_acc = 0; m_cnt = 0;
`ifdef OPERAND_ENTRY_AUTOSWAP_EN
                if (was_x != 0) m_sel = 1;
`endif
            end else begin
                m_acc = m_acc * 10 + k;
                m_cnt = m_cnt + 1;
            end
        end else if (k <= 13) begin
            if (m_cnt > 0) model_write(m_acc);
            m_acc = 0; m_cnt = 0;
            m_op = (k == 13) ? 0 : k - 9;
        end else begin
            if (m_cnt > 0) model_write(m_acc);
            m_acc = 0; m_cnt = 0;
            m_sel = (k == 15) ? 1 : 0;
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_x"},    x,      m_x);
        chk({tag, "_y"},    y,      m_y);
        chk({tag, "_op"},   op,     m_op);
        chk({tag, "_ledX"}, ledX,   (m_sel == 0) ? 1 : 0);
        chk({tag, "_ledY"}, ledY,   (m_sel == 1) ? 1 : 0);
    endtask

    // One key press: drive, verify nothing changes early, verify the consuming edge, verify commit drops.
    task automatic press(input logic [3:0] k);
        @(negedge clk);
        num     = k;
        pressed = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("early_commit", commit, 0);
        chk_state("early");
        model_key(int'(k));
        @(posedge clk);
        @(negedge clk);
        chk("commit", commit, m_commit);
        chk_state("key");
        pressed = 1'b0;
        @(negedge clk);
        chk("commit_drop", commit, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        pressed  = 1'b0;
        num      = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_x", x, 0);
        chk("rst_commit", commit, 0);
        chk("rst_ledX", ledX, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Two digits complete X.
        press(4'd4);
        press(4'd2);
        chk("case2_x", x, 42);

        // Select Y and enter 99; X keeps its value.
        press(4'd15);
        press(4'd9);
        press(4'd9);
        chk("case3_y", y, 99);
        chk("case3_x", x, 42);

        // Partial X committed by operator key, then operator change without commit.
        press(4'd14);
        press(4'd7);
        press(4'd11);
        chk("case4_x", x, 7);
        chk("case4_op", op, 2);
        press(4'd13);
        chk("case4_op0", op, 0);

        // Held key yields a single event; no commit is ever seen.
        @(negedge clk);
        num     = 4'd3;
        pressed = 1'b1;
        repeat (100) begin
            @(negedge clk);
            chk("hold_commit", commit, 0);
        end
        model_key(3);
        pressed = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset away from any clock edge clears outputs immediately.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_x", x, 0);
        chk("arst_y", y, 0);
        chk("arst_op", op, 0);
        chk("arst_ledX", ledX, 1);
        chk("arst_ledY", ledY, 0);
        chk("arst_commit", commit, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        press(4'd5);
        press(4'd6);
        chk("case5_x", x, 56);

        // A press held across reset deassertion still produces exactly one event.
        @(negedge clk);
        rst_n   = 1'b0;
        num     = 4'd15;
        pressed = 1'b1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rstheld_early_ledY", ledY, 0);
        @(posedge clk);
        @(negedge clk);
        model_key(15);
        chk("rstheld_ledY", ledY, 1);
        repeat (5) @(negedge clk);
        chk("rstheld_once_ledY", ledY, 1);
        pressed = 1'b0;
        repeat (3) @(negedge clk);

        // Full-length entry into X, then into Y (selection behaviour follows the build option).
        do_reset();
        press(4'd1);
        press(4'd2);
        chk("case6_x", x, 12);
        press(4'd3);
        press(4'd4);
`ifdef OPERAND_ENTRY_AUTOSWAP_EN
        chk("case6_y", y, 34);
        chk("case6_ledY", ledY, 1);
`else
        chk("case6_x2", x, 34);
        chk("case6_ledY", ledY, 0);
`endif

        // Random key stream against the model.
        do_reset();
        for (int i = 0; i < 250; i++) begin
            press(4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
